// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic-unit arbiter: op encodings,
// default sizing and the result-register state type.
package logic_pkg;

  localparam int LOP_NREQ_DEFAULT  = 4;
  localparam int LOP_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    LOP_AND = 2'b00,
    LOP_OR  = 2'b01,
    LOP_XOR = 2'b10,
    LOP_NOR = 2'b11
  } lop_e;

  // The result register is either empty or holding one undelivered result.
  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin priority picker: the first requester found scanning upward
// from ptr (wrapping modulo NREQ) wins.
module rr_arbiter_core #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any_req
);

  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester to ptr is written last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any_req) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one registered bitwise logic unit among NREQ requesters with
// round-robin grants and a single tagged response channel.
module logic_op_arbiter
  import logic_pkg::*;
#(
  parameter int NREQ  = LOP_NREQ_DEFAULT,
  parameter int WIDTH = LOP_WIDTH_DEFAULT,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic [IDW-1:0]        resp_id,
  output logic [31:0]           grant_count
);

  resp_state_e      state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   winner;
  logic             any_req;
  logic             can_accept;
  logic             accept;
  logic             drain;
  lop_e             sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  rr_arbiter_core #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .winner  (winner),
    .any_req (any_req)
  );

  // A draining consumer frees the register in the same cycle, so a new op can enter without a bubble.
  assign resp_valid = (state_q == RESP_FULL);
  assign can_accept = !resp_valid || resp_ready;
  assign accept     = any_req && can_accept;
  assign drain      = resp_valid && resp_ready;
  assign req_ready  = can_accept ? grant : '0;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RESP_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESP_EMPTY: if (accept) state_d = RESP_FULL;
      RESP_FULL:  if (drain && !accept) state_d = RESP_EMPTY;
      default:    state_d = RESP_EMPTY;
    endcase
  end

  always_comb begin
    sel_op = LOP_AND;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_op = lop_e'(req_op[2*i +: 2]);
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    result = '0;
    case (sel_op)
      LOP_AND: result = sel_a & sel_b;
      LOP_OR:  result = sel_a | sel_b;
      LOP_XOR: result = sel_a ^ sel_b;
      LOP_NOR: result = ~(sel_a | sel_b);
      default: result = '0;
    endcase
  end

  // Result, tag, pointer and counter only move on an accept; a plain drain leaves them as they were.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      resp_data   <= '0;
      resp_id     <= '0;
      grant_count <= '0;
    end else if (accept) begin
      rr_ptr      <= winner + IDW'(1);
      resp_data   <= result;
      resp_id     <= winner;
      grant_count <= grant_count + 32'd1;
    end
  end

endmodule
